// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants for the PS/2 keyboard front end: Set-2
//                scan codes, the 5-bit key codes handed to the hangman
//                datapath, frame/decoder state encodings and the scan-code
//                to key-code map.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    // Set-2 make codes for the keys the game uses
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_B     = 8'h32;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_E     = 8'h24;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_I     = 8'h43;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_K     = 8'h42;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_N     = 8'h31;
    localparam logic [7:0] SC_O     = 8'h44;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_Q     = 8'h15;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_T     = 8'h2C;
    localparam logic [7:0] SC_U     = 8'h3C;
    localparam logic [7:0] SC_V     = 8'h2A;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_Y     = 8'h35;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    // Key codes seen by the datapath
    localparam logic [4:0] KEY_NONE  = 5'd0;
    localparam logic [4:0] KEY_ENTER = 5'd30;
    localparam logic [4:0] KEY_BKSP  = 5'd31;

    typedef enum logic [1:0] {
        FR_IDLE   = 2'd0,
        FR_DATA   = 2'd1,
        FR_PARITY = 2'd2,
        FR_STOP   = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL  = 2'd0,
        DEC_EXT     = 2'd1,
        DEC_BRK     = 2'd2,
        DEC_EXT_BRK = 2'd3
    } dec_state_t;

    // Unmapped codes (including the E0/F0 prefixes) return KEY_NONE.
    function automatic logic [4:0] scan_to_key(input logic [7:0] sc);
        logic [4:0] key;
        key = KEY_NONE;
        case (sc)
            SC_A:     key = 5'd1;
            SC_B:     key = 5'd2;
            SC_C:     key = 5'd3;
            SC_D:     key = 5'd4;
            SC_E:     key = 5'd5;
            SC_F:     key = 5'd6;
            SC_G:     key = 5'd7;
            SC_H:     key = 5'd8;
            SC_I:     key = 5'd9;
            SC_J:     key = 5'd10;
            SC_K:     key = 5'd11;
            SC_L:     key = 5'd12;
            SC_M:     key = 5'd13;
            SC_N:     key = 5'd14;
            SC_O:     key = 5'd15;
            SC_P:     key = 5'd16;
            SC_Q:     key = 5'd17;
            SC_R:     key = 5'd18;
            SC_S:     key = 5'd19;
            SC_T:     key = 5'd20;
            SC_U:     key = 5'd21;
            SC_V:     key = 5'd22;
            SC_W:     key = 5'd23;
            SC_X:     key = 5'd24;
            SC_Y:     key = 5'd25;
            SC_Z:     key = 5'd26;
            SC_ENTER: key = KEY_ENTER;
            SC_BKSP:  key = KEY_BKSP;
            default:  key = KEY_NONE;
        endcase
        return key;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : PS/2 frame receiver. Synchronizes the raw pins, detects
//                falling edges of the PS/2 clock and assembles 11-bit frames
//                (start, 8 data LSB first, odd parity, stop).
//  Ports       : clk, rst (async, active high)
//                ps2_clk, ps2_dat - raw asynchronous pins
//                rx_byte    - last received byte (valid with byte_valid)
//                byte_valid - one-cycle strobe, good frame received
//                err        - one-cycle strobe, parity/stop/timeout error
//                busy       - frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int BIT_TIMEOUT = 6000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err,
    output logic       busy
);

    localparam int WD_W = $clog2(BIT_TIMEOUT + 1);

    // Synchronizers; clk_prev_q holds the previous synced clock for edge detect
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic dat_s1_q, dat_s2_q;

    frame_state_t    state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            byte_valid_q, byte_valid_d;
    logic            err_q, err_d;

    logic w_fall;
    logic w_timeout;

    assign w_fall    = clk_prev_q & ~clk_s2_q;
    // A falling edge in the same cycle restarts the watchdog instead
    assign w_timeout = (state_q != FR_IDLE) && !w_fall &&
                       (wdog_q == WD_W'(BIT_TIMEOUT));

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            dat_s1_q     <= 1'b1;
            dat_s2_q     <= 1'b1;
            state_q      <= FR_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            wdog_q       <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            dat_s1_q     <= ps2_dat;
            dat_s2_q     <= dat_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            wdog_q       <= wdog_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (w_fall) begin
            case (state_q)
                FR_IDLE:   if (!dat_s2_q) state_d = FR_DATA;
                FR_DATA:   if (bit_cnt_q == 3'd7) state_d = FR_PARITY;
                FR_PARITY: state_d = FR_STOP;
                FR_STOP:   state_d = FR_IDLE;
            endcase
        end else if (w_timeout) begin
            state_d = FR_IDLE;
        end
    end

    // Datapath and strobes
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_valid_d = 1'b0;
        err_d        = w_timeout;
        wdog_d       = (state_q == FR_IDLE || w_fall) ? '0 : wdog_q + 1'b1;
        if (w_fall) begin
            case (state_q)
                FR_IDLE:   bit_cnt_d = 3'd0;
                FR_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                FR_PARITY: parity_d = dat_s2_q;
                FR_STOP: begin
                    // Odd parity: data bits plus parity bit XOR to 1
                    if (dat_s2_q && ((^shift_q) ^ parity_q))
                        byte_valid_d = 1'b1;
                    else
                        err_d = 1'b1;
                end
            endcase
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;
    assign busy       = (state_q != FR_IDLE);

endmodule
`default_nettype wire

// File: rtl/ps2_letter_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_letter_rx
//  Description : PS/2 keyboard front end for the hangman datapath. Decodes
//                Set-2 make codes for A..Z, Enter and Backspace into 5-bit
//                key codes, filtering break codes, extended keys, unmapped
//                keys and (optionally) typematic repeats.
//  Ports       : clk, resetn (async, active-high despite the name)
//                ps2_clk, ps2_dat - raw PS/2 pins
//                key_code  - 1..26 A..Z, 30 Enter, 31 Backspace, 0 none
//                key_valid - one-cycle strobe for an accepted key
//                frame_err - one-cycle strobe on a bad/aborted frame
//                busy      - PS/2 frame in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_letter_rx
    import ps2_pkg::*;
#(
    parameter int BIT_TIMEOUT     = 6000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] key_code,
    output logic       key_valid,
    output logic       frame_err,
    output logic       busy
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_err;
    logic       w_rx_busy;
    logic [4:0] w_key;

    dec_state_t dec_state_q, dec_state_d;
    logic [7:0] held_code_q, held_code_d;
    logic [4:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;

    ps2_frame_rx #(
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_rx_valid),
        .err        (w_rx_err),
        .busy       (w_rx_busy)
    );

    assign w_key = scan_to_key(w_rx_byte);

    // State register
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            dec_state_q <= DEC_NORMAL;
            held_code_q <= 8'd0;
            key_code_q  <= KEY_NONE;
            key_valid_q <= 1'b0;
        end else begin
            dec_state_q <= dec_state_d;
            held_code_q <= held_code_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    // Next-state logic: prefix tracking, one step per received byte
    always_comb begin
        dec_state_d = dec_state_q;
        if (w_rx_err) begin
            dec_state_d = DEC_NORMAL;
        end else if (w_rx_valid) begin
            case (dec_state_q)
                DEC_NORMAL: begin
                    if (w_rx_byte == SC_E0)
                        dec_state_d = DEC_EXT;
                    else if (w_rx_byte == SC_F0)
                        dec_state_d = DEC_BRK;
                end
                DEC_EXT:     dec_state_d = (w_rx_byte == SC_F0) ? DEC_EXT_BRK : DEC_NORMAL;
                DEC_BRK:     dec_state_d = DEC_NORMAL;
                DEC_EXT_BRK: dec_state_d = DEC_NORMAL;
            endcase
        end
    end

    // Outputs: key strobe on a new make, held-key bookkeeping on its break
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        held_code_d = held_code_q;
        if (w_rx_valid) begin
            case (dec_state_q)
                DEC_NORMAL: begin
                    // E0/F0 map to KEY_NONE, so prefixes never reach here
                    if (w_key != KEY_NONE &&
                        !(SUPPRESS_REPEAT && w_rx_byte == held_code_q)) begin
                        key_code_d  = w_key;
                        key_valid_d = 1'b1;
                        held_code_d = w_rx_byte;
                    end
                end
                DEC_BRK: begin
                    if (w_rx_byte == held_code_q)
                        held_code_d = 8'd0;
                end
                default: ;
            endcase
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign frame_err = w_rx_err;
    assign busy      = w_rx_busy;

endmodule
`default_nettype wire

// File: tb/tb_ps2_letter_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_letter_rx
//  Description : Randomized self-checking bench for ps2_letter_rx. Two DUTs
//                share the PS/2 pins: one with repeat suppression, one
//                without. A scan-code level reference model predicts key
//                strobes, key codes and frame errors for every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_letter_rx;

    localparam int H = 8;   // PS/2 half bit period in clk cycles

    logic       clk = 1'b0;
    logic       resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [4:0] kc_s, kc_n;
    logic       kv_s, kv_n, fe_s, fe_n, bz_s, bz_n;

    always #5 clk = ~clk;

    ps2_letter_rx #(.BIT_TIMEOUT(6000), .SUPPRESS_REPEAT(1'b1)) u_dut_s (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_code(kc_s), .key_valid(kv_s), .frame_err(fe_s), .busy(bz_s)
    );

    ps2_letter_rx #(.BIT_TIMEOUT(6000), .SUPPRESS_REPEAT(1'b0)) u_dut_n (
        .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .key_code(kc_n), .key_valid(kv_n), .frame_err(fe_n), .busy(bz_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stop_cyc = -100;
    int kv_cnt_s = 0, kv_cnt_n = 0, fe_cnt_s = 0, fe_cnt_n = 0;
    logic kv_s_prev = 1'b0, kv_n_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses, checks latency from the stop-bit edge
    // (2 synchronizer cycles + 2 pipeline cycles) and single-cycle width.
    always @(negedge clk) begin
        if (kv_s) begin
            kv_cnt_s++;
            check_val("latency_s", cyc - stop_cyc, 4);
            check_val("single_s", kv_s_prev, 0);
        end
        if (kv_n) begin
            kv_cnt_n++;
            check_val("latency_n", cyc - stop_cyc, 4);
            check_val("single_n", kv_n_prev, 0);
        end
        if (fe_s) fe_cnt_s++;
        if (fe_n) fe_cnt_n++;
        kv_s_prev = kv_s;
        kv_n_prev = kv_n;
    end

    // ---------------- reference model ----------------
    logic [7:0] lt [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    bit         m_ext = 0, m_brk = 0;
    logic [7:0] m_held_s = 8'd0, m_held_n = 8'd0;
    logic [4:0] m_code_s = 5'd0, m_code_n = 5'd0;

    function automatic int ref_map(input logic [7:0] b);
        for (int i = 0; i < 26; i++)
            if (b == lt[i]) return i + 1;
        if (b == 8'h5A) return 30;
        if (b == 8'h66) return 31;
        return 0;
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit good, output int xs, output int xn);
        int k;
        xs = 0;
        xn = 0;
        if (!good) begin
            m_ext = 0;
            m_brk = 0;
        end else if (m_ext && m_brk) begin
            m_ext = 0;
            m_brk = 0;
        end else if (m_brk) begin
            if (b == m_held_s) m_held_s = 8'd0;
            if (b == m_held_n) m_held_n = 8'd0;
            m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else m_ext = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = ref_map(b);
            if (k != 0) begin
                if (b != m_held_s) begin
                    xs = 1;
                    m_code_s = k[4:0];
                    m_held_s = b;
                end
                xn = 1;
                m_code_n = k[4:0];
                m_held_n = b;
            end
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0;
        m_held_s = 8'd0; m_held_n = 8'd0;
        m_code_s = 5'd0; m_code_n = 5'd0;
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic v, input bit is_stop);
        ps2_dat = v;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) send_bit(b[i], 0);
        send_bit((~^b) ^ bad_par, 0);
        send_bit(~bad_stop, 1);
        ps2_dat = 1'b1;
    endtask

    task automatic frame_check(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int s0, n0, es0, en0, xs, xn, xe;
        s0 = kv_cnt_s; n0 = kv_cnt_n; es0 = fe_cnt_s; en0 = fe_cnt_n;
        xe = (bad_par || bad_stop) ? 1 : 0;
        model_frame(b, xe == 0, xs, xn);
        send_frame(b, bad_par, bad_stop);
        repeat (12) @(negedge clk);
        check_val("kv_count_s", kv_cnt_s - s0, xs);
        check_val("kv_count_n", kv_cnt_n - n0, xn);
        check_val("key_code_s", kc_s, m_code_s);
        check_val("key_code_n", kc_n, m_code_n);
        check_val("frame_err_s", fe_cnt_s - es0, xe);
        check_val("frame_err_n", fe_cnt_n - en0, xe);
        check_val("busy_idle", bz_s, 0);
    endtask

    logic [7:0] rb;
    logic [7:0] last_make;
    int         r, j, es0;

    initial begin
        resetn  = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_key_code", kc_s, 0);
        check_val("rst_key_valid", kv_s, 0);
        check_val("rst_frame_err", fe_s, 0);
        check_val("rst_busy", bz_s, 0);

        // Directed: basic letter, repeat suppression, specials, extended
        frame_check(8'h1C, 0, 0);
        frame_check(8'h1C, 0, 0);
        frame_check(8'hF0, 0, 0);
        frame_check(8'h1C, 0, 0);
        frame_check(8'h1C, 0, 0);
        frame_check(8'h5A, 0, 0);
        frame_check(8'h66, 0, 0);
        frame_check(8'hE0, 0, 0);
        frame_check(8'h5A, 0, 0);
        frame_check(8'hE0, 0, 0);
        frame_check(8'hF0, 0, 0);
        frame_check(8'h5A, 0, 0);
        // Parity error then the same key cleanly
        frame_check(8'h24, 1, 0);
        frame_check(8'h24, 0, 0);

        // Randomized frames
        last_make = 8'h1C;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                j = $urandom_range(0, 27);
                rb = (j < 26) ? lt[j] : ((j == 26) ? 8'h5A : 8'h66);
                last_make = rb;
            end else if (r == 5) rb = 8'hE0;
            else if (r == 6) rb = 8'hF0;
            else if (r <= 8) rb = last_make;
            else rb = 8'($urandom);
            frame_check(rb, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        // Watchdog: abandon a frame after 4 data bits
        es0 = fe_cnt_s;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0);
        ps2_dat = 1'b1;
        repeat (5900) @(negedge clk);
        check_val("wdog_busy_before", bz_s, 1);
        check_val("wdog_err_before", fe_cnt_s - es0, 0);
        repeat (1100) @(negedge clk);
        check_val("wdog_err_after", fe_cnt_s - es0, 1);
        check_val("wdog_busy_after", bz_s, 0);
        model_frame(8'h00, 0, j, r);
        frame_check(8'h2C, 0, 0);

        // Asynchronous reset in the middle of a frame
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        resetn = 1'b1;
        #1;
        check_val("async_key_code_s", kc_s, 0);
        check_val("async_key_code_n", kc_n, 0);
        check_val("async_key_valid", kv_s, 0);
        check_val("async_frame_err", fe_s, 0);
        check_val("async_busy", bz_s, 0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        frame_check(8'h1A, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
